// File: rtl/nios2_oci_trace_pkg.sv
// Shared types and helpers for the OCI trace capture unit.
package nios2_oci_trace_pkg;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } trace_state_e;

  localparam int DEF_DCT_WIDTH   = 30;
  localparam int DEF_COUNT_WIDTH = 4;
  localparam int DEF_ENTRY_W     = DEF_COUNT_WIDTH + DEF_DCT_WIDTH;

  // Width of one stored FIFO entry: {tag, payload}.
  function automatic int entry_width(input int count_w, input int dct_w);
    return count_w + dct_w;
  endfunction

  // Increment that holds at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] mx;
    mx = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= mx) ? mx : v + 32'd1;
  endfunction

endpackage

// File: rtl/nios2_oci_trace_fifo.sv
// First-word-fall-through FIFO; the head is visible the cycle after it is written.
module nios2_oci_trace_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage; cleared on reset so no stale frame survives a restart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; flush dominates any push or pop in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign valid = (level != '0);
  // Head is forced to zero when empty so the read port never shows stale data.
  assign dout  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/nios2_oci_trace_capture.sv
// Trace capture: FIFO of {dct_count, dct_buffer} frames, drop accounting and
// a capture/drain/done state machine controlled by the test-end signals.
module nios2_oci_trace_capture
  import nios2_oci_trace_pkg::*;
#(
  parameter int DCT_WIDTH   = 30,
  parameter int COUNT_WIDTH = 4,
  parameter int DEPTH       = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DCT_WIDTH-1:0]     dct_buffer,
  input  logic [COUNT_WIDTH-1:0]   dct_count,
  input  logic                     dct_push,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DCT_WIDTH-1:0]     out_data,
  output logic [COUNT_WIDTH-1:0]   out_count,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_WIDTH-1:0]     frame_count,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic                     done
);

  localparam int LW = $clog2(DEPTH);
  localparam int EW = entry_width(COUNT_WIDTH, DCT_WIDTH);

  trace_state_e    state;
  logic            pop;
  logic            full;
  logic            flush;
  logic            cap_push;
  logic            push_acc;
  logic            push_drop;
  logic [EW-1:0]   head;

  assign pop       = out_valid && out_ready;
  assign full      = (level == (LW+1)'(DEPTH));
  // Abort flushes on the edge that enters DONE.
  assign flush     = test_has_ended && (state != DONE);
  assign cap_push  = (state == CAPTURE) && dct_push && !test_has_ended;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_acc  = cap_push && (!full || pop);
  assign push_drop = cap_push && full && !pop;

  nios2_oci_trace_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_acc),
    .pop     (pop),
    .flush   (flush),
    .din     ({dct_count, dct_buffer}),
    .dout    (head),
    .valid   (out_valid),
    .level   (level)
  );

  assign {out_count, out_data} = head;

  // Frame/drop accounting; only reachable in CAPTURE, so frozen afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push_acc)
        frame_count <= CNT_WIDTH'(sat_inc(32'(frame_count), CNT_WIDTH));
      if (push_drop) begin
        drop_count <= CNT_WIDTH'(sat_inc(32'(drop_count), CNT_WIDTH));
        overflow   <= 1'b1;
      end
    end
  end

  // Capture/drain/done control; done is sticky until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CAPTURE;
      done  <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          if (test_has_ended) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (test_ending) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (test_has_ended || level == '0 ||
              (level == (LW+1)'(1) && pop)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: begin
          state <= DONE;
          done  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Bench for nios2_oci_trace_capture: a queue-based reference model updated
// on every falling edge, plus directed checks of the scenario end points.
module tb_nios2_oci_trace_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [29:0] dct_buffer = '0;
  logic [3:0]  dct_count = '0;
  logic        dct_push = 1'b0;
  logic        test_ending = 1'b0;
  logic        test_has_ended = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [29:0] out_data;
  logic [3:0]  out_count;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] frame_count;
  logic [15:0] drop_count;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  nios2_oci_trace_capture dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_push       (dct_push),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_count      (out_count),
    .level          (level),
    .overflow       (overflow),
    .frame_count    (frame_count),
    .drop_count     (drop_count),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queue of {tag, payload}, state 0=capture 1=drain 2=done.
  logic [33:0] mq[$];
  int          m_state = 0;
  logic [15:0] m_frame = '0;
  logic [15:0] m_drop  = '0;
  logic        m_ovf   = 1'b0;
  logic        m_done  = 1'b0;

  // Check DUT against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_state = 0; m_frame = '0; m_drop = '0; m_ovf = 1'b0; m_done = 1'b0;
    end else begin
      logic m_pop;
      chk("valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("data", out_data, mq[0][29:0]);
        chk("tag", out_count, mq[0][33:30]);
      end
      chk("level", level, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("frame_count", frame_count, m_frame);
      chk("drop_count", drop_count, m_drop);
      chk("done", done, m_done);

      m_pop = (mq.size() != 0) && out_ready;
      if (m_state != 2 && test_has_ended) begin
        mq.delete();
        m_state = 2;
        m_done  = 1'b1;
      end else if (m_state == 0) begin
        logic can;
        can = dct_push && (mq.size() < 16 || m_pop);
        if (dct_push && !can) begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
        if (m_pop) void'(mq.pop_front());
        if (can) begin
          mq.push_back({dct_count, dct_buffer});
          if (m_frame != 16'hFFFF) m_frame = m_frame + 16'd1;
        end
        if (test_ending) m_state = 1;
      end else if (m_state == 1) begin
        if (mq.size() == 0 || (mq.size() == 1 && m_pop)) begin
          m_state = 2;
          m_done  = 1'b1;
        end
        if (m_pop) void'(mq.pop_front());
      end
    end
  end

  // One clock with the given push inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic p, input logic [29:0] d, input logic [3:0] c);
    dct_push = p; dct_buffer = d; dct_count = c;
    @(posedge clk); #1;
    dct_push = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    dct_push = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_valid"}, out_valid, 0);
    chk({pfx, "_data"}, out_data, 0);
    chk({pfx, "_tag"}, out_count, 0);
    chk({pfx, "_level"}, level, 0);
    chk({pfx, "_ovf"}, overflow, 0);
    chk({pfx, "_frames"}, frame_count, 0);
    chk({pfx, "_drops"}, drop_count, 0);
    chk({pfx, "_done"}, done, 0);
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    chk_zero("rst");
    do_reset();

    // Basic flow
    for (int i = 1; i <= 5; i++) cyc(1'b1, 30'(i), 4'(i));
    idle(2);
    chk("basic_frames", frame_count, 5);
    chk("basic_level", level, 0);
    chk("basic_ovf", overflow, 0);

    // Overflow, then full with simultaneous pop, then drain
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) cyc(1'b1, 30'h100 + 30'(i), 4'(i));
    chk("ovf_level", level, 16);
    chk("ovf_drops", drop_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_frames", frame_count, 16);
    out_ready = 1'b1;
    cyc(1'b1, 30'h2AAA, 4'hA);
    chk("fullpop_level", level, 16);
    chk("fullpop_frames", frame_count, 17);
    chk("fullpop_drops", drop_count, 4);
    idle(18);
    chk("ovf_emptied", level, 0);

    // Drain
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 30'h300 + 30'(i), 4'(i));
    test_ending = 1'b1;
    idle(1);
    cyc(1'b1, 30'h3FF, 4'hF);
    cyc(1'b1, 30'h3FE, 4'hE);
    chk("drain_frames", frame_count, 3);
    chk("drain_level", level, 3);
    chk("drain_done0", done, 0);
    out_ready = 1'b1;
    idle(2);
    chk("drain_done_early", done, 0);
    idle(1);
    chk("drain_done", done, 1);
    chk("drain_valid", out_valid, 0);

    // Abort
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 30'h400 + 30'(i), 4'(i));
    test_has_ended = 1'b1; test_ending = 1'b1;
    cyc(1'b1, 30'h4FF, 4'hF);
    chk("abort_valid", out_valid, 0);
    chk("abort_level", level, 0);
    chk("abort_done", done, 1);
    chk("abort_frames", frame_count, 8);
    test_has_ended = 1'b0; test_ending = 1'b0;
    cyc(1'b1, 30'h4AA, 4'h1);
    chk("abort_frozen", frame_count, 8);

    // Reset mid-capture
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) cyc(1'b1, 30'h500 + 30'(i), 4'(i));
    out_ready = 1'b1;
    idle(11);
    chk("mid_level", level, 5);
    chk("mid_ovf", overflow, 1);
    #2 reset_n = 1'b0;
    #1 chk_zero("async");
    @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    cyc(1'b1, 30'hABC, 4'h7);
    chk("post_valid", out_valid, 1);
    chk("post_data", out_data, 30'hABC);
    chk("post_tag", out_count, 4'h7);
    idle(2);
    chk("post_level", level, 0);
    chk("post_frames", frame_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nios2_oci_trace_capture.md
Name: nios2_oci_trace_capture

Overview:
Parametrised debug-trace capture unit for the Nios II OCI test path. It accepts trace frames (dct_buffer payload plus dct_count tag) into a first-word-fall-through FIFO and presents them on a valid/ready read port. It tracks overflow and maintains frame counters. A drain/terminate state machine is driven by test_ending and test_has_ended. It sits beside the OCI in simulation systems and in debug-enabled synthesis builds.

Parameters:
DCT_WIDTH, 30, trace payload width
COUNT_WIDTH, 4, trace tag (dct_count) width
DEPTH, 16, FIFO entries; power of two, minimum 2
CNT_WIDTH, 16, width of frame_count and drop_count

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
dct_buffer  in  DCT_WIDTH  trace payload
dct_count  in  COUNT_WIDTH  trace tag stored with the payload
dct_push  in  1  frame strobe; one frame per high cycle
test_ending  in  1  request drain; level-sensitive
test_has_ended  in  1  abort: flush and finish; level-sensitive
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  DCT_WIDTH  head payload
out_count  out  COUNT_WIDTH  head tag
level  out  log2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a push was dropped
frame_count  out  CNT_WIDTH  accepted frames, saturating
drop_count  out  CNT_WIDTH  dropped frames, saturating
done  out  1  sticky: capture finished

Behaviour:
- Reset (async assert, sync deassert by the system): state=CAPTURE. out_valid, overflow and done are 0. out_data, out_count, level, frame_count and drop_count are all 0. FIFO is empty.
- Pop: occurs when out_valid && out_ready. The head advances on that clock edge.
- Push accepted: state==CAPTURE && dct_push && (level<DEPTH || pop this cycle).
  - The FIFO stores {dct_count, dct_buffer}.
  - frame_count increments, holding at all-ones.
- Push dropped: state==CAPTURE && dct_push && level==DEPTH && no pop.
  - overflow is set (sticky until reset).
  - drop_count increments, holding at all-ones.
- Pushes in DRAIN or DONE are ignored. They are not counted and do not set overflow.
- Latency: a frame pushed into an empty FIFO at edge N gives out_valid=1 after edge N, with out_data equal to that frame. No bypass within the same cycle.
- Simultaneous push and pop: level is unchanged. When full, the push is accepted.
- level updates as level + push_accepted − pop. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- FSM states:
  - CAPTURE: test_has_ended → DONE. Otherwise test_ending → DRAIN.
  - DRAIN: test_has_ended → DONE. Otherwise level==0, or level==1 with a pop this cycle → DONE.
  - DONE: terminal until reset_n is asserted. done=1.
- test_has_ended priority: it wins over test_ending and over any push or pop in the same cycle. On the entry edge to DONE the FIFO is flushed: level=0 and pointers reset. out_valid=0 after that edge.
- Drain completion: on normal DRAIN→DONE the FIFO is already empty. done rises on the same edge that pops the last entry.
- Counters and overflow are frozen in DONE and remain readable.
- Reset mid-operation clears everything, including the FIFO contents and sticky flags.

Decomposition:
- Package nios2_oci_trace_pkg holds:
  - the state encoding (CAPTURE=2'd0, DRAIN=2'd1, DONE=2'd2) and a helper constant for the entry width (COUNT_WIDTH+DCT_WIDTH);
  - the saturating-increment function.
- One sub-module, nios2_oci_trace_fifo: a synchronous FWFT FIFO parametrised by WIDTH and DEPTH.
  - Ports: push, pop, flush, din, dout, valid, level.
  - Top-level FSM, counters and flags live in nios2_oci_trace_capture.

Test Plan:
- Basic flow (DEPTH=16, out_ready=1):
  - Stimulus: push frames 0x0000001 to 0x0000005, dct_count 1 to 5, one per cycle.
  - Required response: each appears one cycle later in order; frame_count=5, level ends at 0, overflow=0.
- Overflow (out_ready=0):
  - Stimulus: push 20 frames.
  - Required response: level=16, drop_count=4, overflow=1, frame_count=16.
  - Then raise out_ready: the 16 oldest frames drain in order.
- Full plus simultaneous pop:
  - Stimulus: with level=16, push and pop in the same cycle.
  - Required response: level stays 16, frame_count increments, drop_count unchanged.
- Drain:
  - Stimulus: with 3 entries and out_ready=0, assert test_ending and push 2 more frames.
  - Required response: pushes ignored, frame_count unchanged. With out_ready=1, done rises on the edge popping the 3rd entry.
- Abort:
  - Stimulus: with 8 entries, assert test_has_ended together with test_ending and dct_push.
  - Required response: next cycle out_valid=0, level=0, done=1, frame_count unchanged.
- Reset mid-capture:
  - Stimulus: with level=5 and overflow=1, pulse reset_n low asynchronously between edges.
  - Required response: all outputs 0 immediately. After release, the first push behaves as in the basic-flow case.
